// File: rtl/mips_register_file_pkg.sv
// Shared constants and helpers for the MIPS 32 x 32-bit register file.
package mips_register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    // Named architectural registers.
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_WIDTH-1:0] REG_AT   = 5'd1;
    localparam logic [ADDR_WIDTH-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_WIDTH-1:0] REG_RA   = 5'd31;

    typedef logic [DATA_WIDTH-1:0] word_t;

    // True when the address selects the hardwired-zero register.
    function automatic logic is_reg_zero(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/mips_register_file_reg32_en.sv
// One DATA_WIDTH-bit register: D flip-flops with async active-high clear
// and a load-enable mux in front of D.
module reg32_en
    import mips_register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] q_out
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    // Load-enable mux: take new data when enabled, otherwise recirculate.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d_in;
        end else begin
            data_d = data_q;
        end
    end

    // Storage flops; reset clears without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q_out = data_q;

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one
// synchronous write port, register $0 hardwired to zero. There is no
// write-through bypass: a same-cycle read sees the old value until the edge.
module mips_register_file
    import mips_register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    logic                  write_hit_s;
    logic [NUM_REGS-1:1]   wr_en_s;
    logic [DATA_WIDTH-1:0] regs_s [NUM_REGS];

    // Writes to $0 are dropped before decode so register 0 never loads.
    always_comb begin
        write_hit_s = 1'b0;
        if (reg_write && !is_reg_zero(write_reg)) begin
            write_hit_s = 1'b1;
        end else begin
            write_hit_s = 1'b0;
        end
    end

    // One-hot 5-to-32 write decode gated by the write enable.
    always_comb begin
        wr_en_s = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            wr_en_s[i] = write_hit_s && (write_reg == ADDR_WIDTH'(i));
        end
    end

    // Register $0 has no storage.
    assign regs_s[0] = {DATA_WIDTH{1'b0}};

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            reg32_en u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (wr_en_s[gi]),
                .d_in  (write_data),
                .q_out (regs_s[gi])
            );
        end
    endgenerate

    // Read port 1: combinational 32:1 select (ALU operand A).
    always_comb begin
        read_data1 = regs_s[read_reg1];
    end

    // Read port 2: combinational 32:1 select (ALU operand B / store data).
    always_comb begin
        read_data2 = regs_s[read_reg2];
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: stimulus pushes expected read
// values computed from an array model; a monitor pops and compares.
`timescale 1ns/1ps
module tb_mips_register_file;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    mips_register_file dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // Long half period so many combinational reads fit in one clock phase.
    initial clk = 1'b0;
    always #100 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0: port 1, 1: port 2, 2: NOR of both ports
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    event        check_ev;

    // Architectural model operations.
    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset && reg_write && (write_reg != 5'd0)) model[write_reg] = write_data;
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    // Queue the expected values for both read ports, then hand to monitor.
    task automatic check(input string nm);
        exp_t e;
        #1;
        e.name = nm; e.kind = 0; e.exp = model[read_reg1]; sb_q.push_back(e);
        e.name = nm; e.kind = 1; e.exp = model[read_reg2]; sb_q.push_back(e);
        -> check_ev;
        #1;
    endtask

    task automatic check_nor(input string nm, input logic [31:0] exp_v);
        exp_t e;
        #1;
        e.name = nm; e.kind = 2; e.exp = exp_v; sb_q.push_back(e);
        -> check_ev;
        #1;
    endtask

    // Monitor: compare every queued expectation against the DUT outputs.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(check_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    0:       act = read_data1;
                    1:       act = read_data2;
                    2:       act = ~(read_data1 | read_data2);
                    default: act = 32'hx;
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s port=%0d rr1=%0d rr2=%0d got=%h expected=%h",
                             e.name, e.kind, read_reg1, read_reg2, act, e.exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        reg_write  = 1'b0;
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        write_reg  = 5'd0;
        write_data = 32'h0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        // Fill every register, then clear asynchronously mid-phase.
        for (int i = 1; i < 32; i++) wr(5'(i), $urandom());
        read_reg1 = 5'd3; read_reg2 = 5'd29;
        check("fill");
        #10;
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            check("rst_sweep");
        end
        tick();
        read_reg1 = 5'd31; read_reg2 = 5'd1;
        check("rst_hold_edge");
        reset = 1'b0;

        // Basic write/read and the NOR unit downstream.
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd6, 32'h0000FFFF);
        read_reg1 = 5'd5; read_reg2 = 5'd6;
        check("basic");
        check_nor("nor", 32'h21520000);

        // $0 protection.
        wr(5'd0, 32'hFFFFFFFF);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        check("zero_reg");

        // Enable gating.
        reg_write = 1'b0; write_reg = 5'd7; write_data = 32'h12345678;
        tick();
        read_reg1 = 5'd7; read_reg2 = 5'd7;
        check("en_gate");

        // Same-cycle read/write: old before edge, new after.
        wr(5'd9, 32'h11111111);
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h22222222;
        read_reg1 = 5'd9; read_reg2 = 5'd9;
        check("rw_old");
        tick();
        reg_write = 1'b0;
        check("rw_new");

        // Reset in the middle of a pending write to $ra.
        wr(5'd31, 32'hCAFEF00D);
        read_reg1 = 5'd31; read_reg2 = 5'd31;
        check("ra_load");
        #20;
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hAAAAAAAA;
        model_clear();
        check("rst_mid");
        tick();
        check("rst_mid_hold");
        reset = 1'b0;
        check("rst_release");
        tick();
        reg_write = 1'b0;
        check("post_rst_write");

        // Randomized traffic, with occasional asynchronous reset pulses.
        for (int n = 0; n < 300; n++) begin
            reg_write  = 1'($urandom_range(0, 1));
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom();
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
            check("rnd_pre");
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                model_clear();
                check("rnd_rst");
                #5;
                reset = 1'b0;
            end
            tick();
            check("rnd_post");
        end

        #5;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d pending expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
